// File: rtl/cb_cfg_pkg.sv
// Shared types and tap mapping for the connection-block configuration engine.
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    // Channel track feeding tap `tap` of ipin mux `ipin`; taps are spread evenly around the channel.
    function automatic int tap_idx(input int ipin, input int tap, input int chan_w, input int mux_size);
        return (2 * ipin + tap * (chan_w / mux_size)) % chan_w;
    endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// One grid input-pin mux: MUX_SIZE channel taps plus a disconnected (drive 0) setting.
module cb_ipin_mux
    import cb_cfg_pkg::*;
#(
    parameter int MUX_SIZE = 6,
    parameter int SEL_W    = 3
) (
    input  logic [MUX_SIZE-1:0] taps,
    input  logic [SEL_W-1:0]    sel,
    output logic                ipin
);

    always_comb begin
        ipin = 1'b0;
        if (32'(sel) < MUX_SIZE) begin
            ipin = taps[sel];
        end
    end

endmodule

// File: rtl/cb_cfg_engine.sv
// Connection-block configuration engine: shadow/active select banks, request FSM, ipin muxes.
// States: IDLE accepts requests | READ drives the readback strobe | COMMIT one-cycle settle after bank swap.
module cb_cfg_engine
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W   = 18,
    parameter int NUM_IPIN = 11,
    parameter int MUX_SIZE = 6,
    localparam int SEL_W   = $clog2(MUX_SIZE + 1),
    localparam int ADDR_W  = $clog2(NUM_IPIN)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic [CHAN_W-1:0] chan_in,
    output logic [CHAN_W-1:0] chan_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [SEL_W-1:0]  cfg_wdata,
    input  logic              cfg_commit,
    output logic              cfg_rvalid,
    output logic [SEL_W-1:0]  cfg_rdata,
    output logic              cfg_err,
    output logic              cfg_dirty
);

    cfg_state_e        state_q, state_d;
    logic [SEL_W-1:0]  shadow_sel_q [NUM_IPIN];
    logic [SEL_W-1:0]  shadow_sel_d [NUM_IPIN];
    logic [SEL_W-1:0]  active_sel_q [NUM_IPIN];
    logic [SEL_W-1:0]  active_sel_d [NUM_IPIN];
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              err_q, err_d;
    logic              dirty_q, dirty_d;
    logic              addr_ok;
    logic              data_ok;

    assign chan_out   = chan_in;
    assign cfg_ready  = (state_q == ST_IDLE) && !cfg_commit;
    assign cfg_rvalid = (state_q == ST_READ);
    assign cfg_rdata  = cfg_rvalid ? shadow_sel_q[raddr_q] : '0;
    assign cfg_err    = err_q;
    assign cfg_dirty  = dirty_q;

    assign addr_ok = 32'(cfg_addr) < NUM_IPIN;
    assign data_ok = !cfg_we || (32'(cfg_wdata) <= MUX_SIZE);

    always_comb begin
        state_d      = state_q;
        shadow_sel_d = shadow_sel_q;
        active_sel_d = active_sel_q;
        raddr_d      = raddr_q;
        err_d        = 1'b0;
        dirty_d      = dirty_q;
        case (state_q)
            ST_IDLE: begin
                // Commit wins over a simultaneous request, which is simply not accepted.
                if (cfg_commit) begin
                    active_sel_d = shadow_sel_q;
                    dirty_d      = 1'b0;
                    state_d      = ST_COMMIT;
                end else if (cfg_valid) begin
                    if (!addr_ok || !data_ok) begin
                        err_d = 1'b1;
                    end else if (cfg_we) begin
                        shadow_sel_d[cfg_addr] = cfg_wdata;
                        dirty_d                = 1'b1;
                    end else begin
                        raddr_d = cfg_addr;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:   state_d = ST_IDLE;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            err_q   <= 1'b0;
            dirty_q <= 1'b0;
            for (int i = 0; i < NUM_IPIN; i++) begin
                shadow_sel_q[i] <= SEL_W'(MUX_SIZE);
                active_sel_q[i] <= SEL_W'(MUX_SIZE);
            end
        end else begin
            state_q      <= state_d;
            raddr_q      <= raddr_d;
            err_q        <= err_d;
            dirty_q      <= dirty_d;
            shadow_sel_q <= shadow_sel_d;
            active_sel_q <= active_sel_d;
        end
    end

    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
        logic [MUX_SIZE-1:0] taps;
        for (genvar k = 0; k < MUX_SIZE; k++) begin : g_tap
            assign taps[k] = chan_in[tap_idx(i, k, CHAN_W, MUX_SIZE)];
        end
        cb_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .taps (taps),
            .sel  (active_sel_q[i]),
            .ipin (ipin_out[i])
        );
    end

endmodule

// File: tb/tb_cb_cfg_engine.sv
// Scoreboard bench for cb_cfg_engine: driver updates a bank-level model, monitor compares on every falling edge.
module tb_cb_cfg_engine;

    localparam int CW = 18;
    localparam int NI = 11;
    localparam int MS = 6;

    logic          prog_clk;
    logic          pReset_n;
    logic [CW-1:0] chan_in;
    logic [CW-1:0] chan_out;
    logic [NI-1:0] ipin_out;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [2:0]    cfg_wdata;
    logic          cfg_commit;
    logic          cfg_rvalid;
    logic [2:0]    cfg_rdata;
    logic          cfg_err;
    logic          cfg_dirty;

    cb_cfg_engine dut (
        .prog_clk   (prog_clk),
        .pReset_n   (pReset_n),
        .chan_in    (chan_in),
        .chan_out   (chan_out),
        .ipin_out   (ipin_out),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .cfg_rvalid (cfg_rvalid),
        .cfg_rdata  (cfg_rdata),
        .cfg_err    (cfg_err),
        .cfg_dirty  (cfg_dirty)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    typedef struct {
        bit is_err;
        int data;
    } resp_t;

    resp_t exp_q [$];
    int    shadow_m [NI];
    int    active_m [NI];
    bit    dirty_m;
    bit    busy_m;
    bit    mon_en;
    int    errors;
    int    checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NI-1:0] model_ipin(input logic [CW-1:0] ch);
        logic [NI-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++) begin
            if (active_m[i] < MS) r[i] = ch[(2 * i + active_m[i] * (CW / MS)) % CW];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            shadow_m[i] = MS;
            active_m[i] = MS;
        end
        dirty_m = 0;
        busy_m  = 0;
        exp_q.delete();
    endtask

    // What the engine does at one clock edge, in bank/response terms.
    task automatic model_edge(input bit v, input bit we, input int addr, input int wd, input bit cm);
        resp_t r;
        if (busy_m) begin
            busy_m = 0;
        end else if (cm) begin
            active_m = shadow_m;
            dirty_m  = 0;
            busy_m   = 1;
        end else if (v) begin
            if (addr >= NI || (we && wd > MS)) begin
                r.is_err = 1; r.data = 0;
                exp_q.push_back(r);
            end else if (we) begin
                shadow_m[addr] = wd;
                dirty_m = 1;
            end else begin
                r.is_err = 0; r.data = shadow_m[addr];
                exp_q.push_back(r);
                busy_m = 1;
            end
        end
    endtask

    task automatic step(input bit v, input bit we, input int addr, input int wd, input bit cm);
        cfg_valid  = v;
        cfg_we     = we;
        cfg_addr   = addr[3:0];
        cfg_wdata  = wd[2:0];
        cfg_commit = cm;
        @(negedge prog_clk);
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, (!busy_m && !cm)});
        @(posedge prog_clk);
        model_edge(v, we, addr, wd, cm);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        cfg_valid  = 0;
        cfg_commit = 0;
        pReset_n   = 0;
        model_reset();
        @(negedge prog_clk);
        @(posedge prog_clk);
        #1;
        pReset_n = 1;
    endtask

    always @(negedge prog_clk) begin
        resp_t r;
        if (mon_en) begin
            chk("chan_out", 32'(chan_out), 32'(chan_in));
            chk("ipin_out", 32'(ipin_out), 32'(model_ipin(chan_in)));
            chk("cfg_dirty", {31'd0, cfg_dirty}, {31'd0, dirty_m});
            if (!cfg_rvalid) chk("rdata_idle", 32'(cfg_rdata), 0);
            if (cfg_rvalid || cfg_err || exp_q.size() > 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {30'd0, cfg_rvalid, cfg_err}, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("resp_kind", {30'd0, cfg_rvalid, cfg_err}, r.is_err ? 32'd1 : 32'd2);
                    if (!r.is_err) chk("rdata", 32'(cfg_rdata), r.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        errors = 0;
        checks = 0;
        mon_en = 0;
        cfg_valid = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
        chan_in  = 18'h3FFFF;
        pReset_n = 0;
        model_reset();
        mon_en = 1;
        @(negedge prog_clk);
        chk("reset_ipin", 32'(ipin_out), 0);
        chk("reset_chan_out", 32'(chan_out), 32'h3FFFF);
        @(posedge prog_clk);
        #1;
        pReset_n = 1;

        // Addr 0 select 2 -> track 6; visible only after the commit edge.
        chan_in = 18'h00040;
        step(1, 1, 0, 2, 0);
        chk("ipin0_before_commit", {31'd0, ipin_out[0]}, 0);
        step(0, 0, 0, 0, 1);
        chk("ipin0_after_commit", {31'd0, ipin_out[0]}, 1);
        idle(1);

        // Addr 10 select 5 -> track 17.
        step(1, 1, 10, 5, 0);
        step(0, 0, 0, 0, 1);
        idle(1);
        chan_in = 18'h20000;
        idle(1);
        chk("ipin10_high", {31'd0, ipin_out[10]}, 1);
        chan_in = 18'h00000;
        idle(1);
        step(1, 0, 10, 0, 0);
        idle(2);

        // Rejected requests leave the shadow bank alone.
        step(1, 1, 11, 1, 0);
        step(1, 1, 3, 7, 0);
        step(1, 0, 3, 0, 0);
        idle(2);

        // Commit beats a simultaneous write.
        step(1, 1, 4, 1, 1);
        idle(1);
        step(1, 0, 4, 0, 0);
        idle(2);

        // Reset while a readback is in flight.
        step(1, 1, 2, 3, 0);
        step(0, 0, 0, 0, 1);
        idle(1);
        step(1, 0, 2, 0, 0);
        apply_reset();
        chk("reset_mid_read_ipin", 32'(ipin_out), 0);
        step(1, 0, 2, 0, 0);
        idle(2);

        for (int n = 0; n < 2000; n++) begin
            chan_in = 18'($urandom);
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
            end else begin
                case (op)
                    0, 1, 2, 3: step(1, 1, $urandom_range(0, 12), $urandom_range(0, 7), 0);
                    4, 5:       step(1, 0, $urandom_range(0, 12), $urandom_range(0, 7), 0);
                    6:          step(0, 0, 0, 0, 1);
                    7:          step(1, 1, $urandom_range(0, 12), $urandom_range(0, 7), 1);
                    8:          step(0, 0, 0, 0, 0);
                    default:    step(1, 0, $urandom_range(0, 12), 0, 1);
                endcase
            end
        end
        idle(3);
        mon_en = 0;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
